alu_mdu: RTL and testbench
==========================

# alu_mdu

Registered, parametrised execute-stage ALU with an integrated iterative multiply/divide unit and HI/LO registers. It sits in the EX stage and replaces the purely combinational ALU. It adds three things:
- a valid/ready handshake, so EX can stall on long operations;
- correct signed-overflow detection for ADD/SUB;
- MIPS MULT/DIV/MFHI/MFLO/MTHI/MTLO semantics.

## Interface
Parameters:
- DATA_W, 32, operand/result width (even, ≥8)
- SH_W, $clog2(DATA_W), significant shift-amount bits of in_0

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous abort of any in-flight op
- in_valid  in  1  op/operands valid
- in_ready  out  1  unit can accept this cycle
- op  in  `AluOpBus  ALU op code; existing `ALU_*` codes plus `ALU_MULT`, `ALU_MULTU`, `ALU_DIV`, `ALU_DIVU`, `ALU_MFHI`, `ALU_MFLO`, `ALU_MTHI`, `ALU_MTLO` added to defines.v
- in_0  in  DATA_W  rs / shamt
- in_1  in  DATA_W  rt / imm
- out_valid  out  1  result valid
- out_ready  in  1  consumer takes result
- out  out  DATA_W  result
- of  out  1  signed overflow (ADD/SUB only), qualified by out_valid
- hi, lo  out  DATA_W  architectural HI/LO registers

## Operation
- Handshake:
  - An op is accepted on a clk edge when in_valid && in_ready.
  - A result retires on a clk edge when out_valid && out_ready.
- in_ready = (state==IDLE) && (!out_valid || out_ready).
- FSM states IDLE, MUL, DIV:
  - IDLE + accept of MULT/MULTU → MUL.
  - IDLE + accept of DIV/DIVU → DIV.
  - All other accepts stay in IDLE and load out/of directly.
- MUL/DIV behaviour:
  - Each step counter counts DATA_W iterations, then writes HI/LO, loads out=LO and out_valid=1, and returns to IDLE.
- Logic/arith ops use the same semantics as the existing ALU.
- Shifts use in_0[SH_W-1:0] only. SRA is arithmetic on in_1. SLA is identical to SLL.
- Overflow:
  - ADD: of = (in_0[MSB]==in_1[MSB]) && (sum[MSB]!=in_0[MSB]).
  - SUB: of = (in_0[MSB]!=in_1[MSB]) && (diff[MSB]!=in_0[MSB]).
  - ADDU/SUBU never flag. When of=1, out still carries the wrapped result.
- MULT/MULTU: 2·DATA_W product, {hi,lo} = in_0 × in_1 (signed / unsigned).
- DIV/DIVU: restoring division on magnitudes, with signs fixed afterwards. lo = quotient (truncates toward zero), hi = remainder (takes the sign of the dividend).
- Divide by zero: lo = all ones, hi = in_0. Takes the full DATA_W-cycle latency. No trap.
- DIV of the most-negative value by −1: lo = most-negative value, hi = 0. No flag.
- MFHI/MFLO: out = hi/lo, latency 1.
- MTHI/MTLO: hi/lo = in_0 on accept; out = in_0; out_valid=1.
- flush:
  - Forces IDLE, clears out_valid and of, and blocks accept in that cycle.
  - HI/LO keep their pre-op values, because a MUL/DIV commits only at completion.
  - flush has priority over completion in the same cycle.

## Timing
- Reset values: out_valid=0, out=0, of=0, hi=0, lo=0, state=IDLE, in_ready=1 (after reset deasserts, combinationally).
- Single-cycle ops: accepted at edge N → out_valid at N+1.
- Iterative MUL/DIV: accepted at edge N → out_valid at N+DATA_W+1. in_ready=0 from N+1 until completion.
- Result hold: out/of are held stable while out_valid && !out_ready.
- Back-to-back: a new single-cycle op may be accepted on the same edge that retires the previous result, so throughput is 1/cycle.
- MFHI/MFLO immediately following MULT/DIV see the updated HI/LO. The producer completes before in_ready rises.
- rst_n asserting mid-operation: immediate (async) return to all reset values.

## Configuration
- `ALU_FAST_MUL_EN` defined:
  - MULT/MULTU use a single-cycle combinational multiplier.
  - Latency is 1, same as logic ops, and the MUL state is unused.
  - DIV stays iterative.
- Not defined: MULT/MULTU take the iterative DATA_W+1 cycle shift-add path. No hardware multiplier is inferred.

## Test plan
- ADD overflow, DATA_W=32:
  - ADD 0x7FFFFFFF + 0x00000001 → out=0x80000000, of=1, out_valid at N+1.
  - ADDU with the same operands → of=0.
- SUB overflow: SUB 0x80000000 − 0x00000001 → out=0x7FFFFFFF, of=1.
- MULT signed: 0xFFFFFFFE (−2) × 0x00000003 → hi=0xFFFFFFFF, lo=0xFFFFFFFA.
  - Macro off: out_valid at N+33 and in_ready low for 32 cycles.
  - Macro on: out_valid at N+1.
- DIV: 0xFFFFFFF9 (−7) ÷ 2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - DIVU 5 ÷ 0 → lo=0xFFFFFFFF, hi=5.
- Backpressure: hold out_ready=0 for 5 cycles after a SLT result → out stable, in_ready=0, no op accepted. Then release → next op accepted on the same edge.
- Abort:
  - flush at cycle 10 of a DIV → out_valid never rises and hi/lo are unchanged.
  - rst_n low mid-MUL → all outputs 0 asynchronously.

Source files
------------

// File: rtl/alu_mdu.sv
// Registered EX-stage ALU with an iterative multiply/divide unit and HI/LO registers.
// Optional macro ALU_FAST_MUL_EN: single-cycle MULT/MULTU (DIV stays iterative).

`ifndef ALU_MDU_OPS_DEFINED
`define ALU_MDU_OPS_DEFINED
`define AluOpBus  4:0
`define ALU_ADD   5'd0
`define ALU_ADDU  5'd1
`define ALU_SUB   5'd2
`define ALU_SUBU  5'd3
`define ALU_AND   5'd4
`define ALU_OR    5'd5
`define ALU_XOR   5'd6
`define ALU_NOR   5'd7
`define ALU_SLT   5'd8
`define ALU_SLTU  5'd9
`define ALU_SLL   5'd10
`define ALU_SRL   5'd11
`define ALU_SRA   5'd12
`define ALU_SLA   5'd13
`define ALU_MULT  5'd14
`define ALU_MULTU 5'd15
`define ALU_DIV   5'd16
`define ALU_DIVU  5'd17
`define ALU_MFHI  5'd18
`define ALU_MFLO  5'd19
`define ALU_MTHI  5'd20
`define ALU_MTLO  5'd21
`endif

module alu_mdu #(
    parameter int DATA_W = 32,
    parameter int SH_W   = $clog2(DATA_W)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [`AluOpBus]  op,
    input  logic [DATA_W-1:0] in_0,
    input  logic [DATA_W-1:0] in_1,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out,
    output logic              of,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo,
    output logic [1:0]        dbg_state
);

    localparam int MSB   = DATA_W - 1;
    localparam int CNT_W = $clog2(DATA_W);

    typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2} state_t;

    state_t state_q, state_d;

    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] acc_hi, acc_lo, opnd;
    logic              neg_q, neg_r, dz;

    // Valid/ready: an op is taken on an edge with in_valid && in_ready (and no flush);
    // a result leaves on an edge with out_valid && out_ready; out/of hold until then.
    assign in_ready  = (state_q == IDLE) && (!out_valid || out_ready);
    assign dbg_state = state_q;

    logic accept, is_signed, start_mul, start_div, last;
    assign accept    = in_valid && in_ready && !flush;
    assign is_signed = (op == `ALU_MULT) || (op == `ALU_DIV);
    assign start_div = (op == `ALU_DIV) || (op == `ALU_DIVU);
`ifdef ALU_FAST_MUL_EN
    assign start_mul = 1'b0;
`else
    assign start_mul = (op == `ALU_MULT) || (op == `ALU_MULTU);
`endif
    assign last = (cnt == CNT_W'(DATA_W - 1));

    logic              a_neg, b_neg;
    logic [DATA_W-1:0] a_mag, b_mag, sum, diff;
    logic [SH_W-1:0]   shamt;
    assign a_neg = is_signed & in_0[MSB];
    assign b_neg = is_signed & in_1[MSB];
    assign a_mag = a_neg ? -in_0 : in_0;
    assign b_mag = b_neg ? -in_1 : in_1;
    assign sum   = in_0 + in_1;
    assign diff  = in_0 - in_1;
    assign shamt = in_0[SH_W-1:0];

    // Single-cycle result plus the HI/LO values such an op leaves behind.
    logic [DATA_W-1:0]   sc_out, sc_hi, sc_lo;
    logic                sc_of;
    logic [2*DATA_W-1:0] fast_prod;
    assign fast_prod = {{DATA_W{is_signed & in_0[MSB]}}, in_0} *
                       {{DATA_W{is_signed & in_1[MSB]}}, in_1};

    always_comb begin
        sc_out = '0;
        sc_of  = 1'b0;
        sc_hi  = hi;
        sc_lo  = lo;
        case (op)
            `ALU_ADD: begin
                sc_out = sum;
                sc_of  = (in_0[MSB] == in_1[MSB]) && (sum[MSB] != in_0[MSB]);
            end
            `ALU_SUB: begin
                sc_out = diff;
                sc_of  = (in_0[MSB] != in_1[MSB]) && (diff[MSB] != in_0[MSB]);
            end
            `ALU_ADDU: sc_out = sum;
            `ALU_SUBU: sc_out = diff;
            `ALU_AND:  sc_out = in_0 & in_1;
            `ALU_OR:   sc_out = in_0 | in_1;
            `ALU_XOR:  sc_out = in_0 ^ in_1;
            `ALU_NOR:  sc_out = ~(in_0 | in_1);
            `ALU_SLT:  sc_out = {{(DATA_W-1){1'b0}}, $signed(in_0) < $signed(in_1)};
            `ALU_SLTU: sc_out = {{(DATA_W-1){1'b0}}, in_0 < in_1};
            `ALU_SLL, `ALU_SLA: sc_out = in_1 << shamt;
            `ALU_SRL:  sc_out = in_1 >> shamt;
            `ALU_SRA:  sc_out = $signed(in_1) >>> shamt;
            `ALU_MFHI: sc_out = hi;
            `ALU_MFLO: sc_out = lo;
            `ALU_MTHI: begin sc_out = in_0; sc_hi = in_0; end
            `ALU_MTLO: begin sc_out = in_0; sc_lo = in_0; end
`ifdef ALU_FAST_MUL_EN
            `ALU_MULT, `ALU_MULTU: begin
                sc_out = fast_prod[DATA_W-1:0];
                sc_hi  = fast_prod[2*DATA_W-1:DATA_W];
                sc_lo  = fast_prod[DATA_W-1:0];
            end
`endif
            default: sc_out = '0;
        endcase
    end

    // One shift-add step: multiplier bits are consumed from the bottom of acc_lo.
    logic [DATA_W:0]     mul_add;
    logic [DATA_W-1:0]   mul_hi_nx, mul_lo_nx;
    logic [2*DATA_W-1:0] prod_raw, prod_fin;
    assign mul_add   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
    assign mul_hi_nx = mul_add[DATA_W:1];
    assign mul_lo_nx = {mul_add[0], acc_lo[DATA_W-1:1]};
    assign prod_raw  = {mul_hi_nx, mul_lo_nx};
    assign prod_fin  = neg_q ? -prod_raw : prod_raw;

    // One restoring-division step: acc_hi is the partial remainder, acc_lo shifts
    // dividend bits out and quotient bits in.
    logic [DATA_W:0]   shifted, trial;
    logic              ge;
    logic [DATA_W-1:0] div_hi_nx, div_lo_nx, q_fin, r_fin;
    assign shifted   = {acc_hi, acc_lo[MSB]};
    assign trial     = shifted - {1'b0, opnd};
    assign ge        = !trial[DATA_W];
    assign div_hi_nx = ge ? trial[DATA_W-1:0] : shifted[DATA_W-1:0];
    assign div_lo_nx = {acc_lo[DATA_W-2:0], ge};
    assign q_fin     = dz ? '1 : (neg_q ? -div_lo_nx : div_lo_nx);
    assign r_fin     = neg_r ? -div_hi_nx : div_hi_nx;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept && start_mul)      state_d = MUL;
                else if (accept && start_div) state_d = DIV;
            end
            MUL, DIV: if (last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (flush) state_d = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out       <= '0;
            of        <= 1'b0;
            hi        <= '0;
            lo        <= '0;
            cnt       <= '0;
            acc_hi    <= '0;
            acc_lo    <= '0;
            opnd      <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            dz        <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
            of        <= 1'b0;
            cnt       <= '0;
        end else begin
            if (out_valid && out_ready) out_valid <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        cnt <= '0;
                        if (start_mul) begin
                            acc_hi <= '0;
                            acc_lo <= b_mag;
                            opnd   <= a_mag;
                            neg_q  <= a_neg ^ b_neg;
                            neg_r  <= 1'b0;
                            dz     <= 1'b0;
                        end else if (start_div) begin
                            acc_hi <= '0;
                            acc_lo <= a_mag;
                            opnd   <= b_mag;
                            neg_q  <= a_neg ^ b_neg;
                            neg_r  <= a_neg;
                            dz     <= (in_1 == '0);
                        end else begin
                            out       <= sc_out;
                            of        <= sc_of;
                            hi        <= sc_hi;
                            lo        <= sc_lo;
                            out_valid <= 1'b1;
                        end
                    end
                end
                MUL: begin
                    acc_hi <= mul_hi_nx;
                    acc_lo <= mul_lo_nx;
                    cnt    <= cnt + 1'b1;
                    if (last) begin
                        hi        <= prod_fin[2*DATA_W-1:DATA_W];
                        lo        <= prod_fin[DATA_W-1:0];
                        out       <= prod_fin[DATA_W-1:0];
                        of        <= 1'b0;
                        out_valid <= 1'b1;
                    end
                end
                DIV: begin
                    acc_hi <= div_hi_nx;
                    acc_lo <= div_lo_nx;
                    cnt    <= cnt + 1'b1;
                    if (last) begin
                        hi        <= r_fin;
                        lo        <= q_fin;
                        out       <= q_fin;
                        of        <= 1'b0;
                        out_valid <= 1'b1;
                    end
                end
                default: cnt <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mdu.sv
// Self-checking bench for alu_mdu: directed corner steps, then random ops against
// an arithmetic reference model of the ALU and HI/LO.
module tb_alu_mdu;
    localparam int W = 32;

    localparam logic [4:0] OP_ADD = 5'd0,  OP_ADDU = 5'd1,  OP_SUB = 5'd2,  OP_SUBU = 5'd3;
    localparam logic [4:0] OP_AND = 5'd4,  OP_OR = 5'd5,    OP_XOR = 5'd6,  OP_NOR = 5'd7;
    localparam logic [4:0] OP_SLT = 5'd8,  OP_SLTU = 5'd9,  OP_SLL = 5'd10, OP_SRL = 5'd11;
    localparam logic [4:0] OP_SRA = 5'd12, OP_SLA = 5'd13,  OP_MULT = 5'd14, OP_MULTU = 5'd15;
    localparam logic [4:0] OP_DIV = 5'd16, OP_DIVU = 5'd17, OP_MFHI = 5'd18, OP_MFLO = 5'd19;
    localparam logic [4:0] OP_MTHI = 5'd20, OP_MTLO = 5'd21;

`ifdef ALU_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = W + 1;
`endif
    localparam int DIV_LAT = W + 1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic         flush = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
    logic [4:0]   op = 5'd0;
    logic [W-1:0] in_0 = '0, in_1 = '0;
    logic         in_ready, out_valid, of;
    logic [W-1:0] out, hi, lo;
    logic [1:0]   dbg_state;

    alu_mdu #(.DATA_W(W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .in_0(in_0), .in_1(in_1),
        .out_valid(out_valid), .out_ready(out_ready),
        .out(out), .of(of), .hi(hi), .lo(lo), .dbg_state(dbg_state)
    );

    int n_vec = 0;
    int n_miss = 0;
    logic [W-1:0] m_hi = '0, m_lo = '0;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // ---------------- reference model ----------------
    task automatic model(input logic [4:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] r, output logic f);
        longint sa, sb, s;
        logic [63:0] u;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r = '0;
        f = 1'b0;
        case (o)
            OP_ADD: begin
                s = sa + sb; r = s[W-1:0];
                f = (s > 64'sh7FFFFFFF) || (s < -64'sh80000000);
            end
            OP_SUB: begin
                s = sa - sb; r = s[W-1:0];
                f = (s > 64'sh7FFFFFFF) || (s < -64'sh80000000);
            end
            OP_ADDU: r = a + b;
            OP_SUBU: r = a - b;
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_NOR:  r = ~(a | b);
            OP_SLT:  r = (sa < sb) ? 1 : 0;
            OP_SLTU: r = (a < b) ? 1 : 0;
            OP_SLL, OP_SLA: r = b << a[4:0];
            OP_SRL:  r = b >> a[4:0];
            OP_SRA:  begin s = sb >>> a[4:0]; r = s[W-1:0]; end
            OP_MULT: begin s = sa * sb; {m_hi, m_lo} = s; r = m_lo; end
            OP_MULTU: begin u = {32'b0, a} * {32'b0, b}; {m_hi, m_lo} = u; r = m_lo; end
            OP_DIV: begin
                if (b == 0) begin m_lo = '1; m_hi = a; end
                else begin s = sa / sb; m_lo = s[W-1:0]; s = sa % sb; m_hi = s[W-1:0]; end
                r = m_lo;
            end
            OP_DIVU: begin
                if (b == 0) begin m_lo = '1; m_hi = a; end
                else begin m_lo = a / b; m_hi = a % b; end
                r = m_lo;
            end
            OP_MFHI: r = m_hi;
            OP_MFLO: r = m_lo;
            OP_MTHI: begin m_hi = a; r = a; end
            OP_MTLO: begin m_lo = a; r = a; end
            default: r = '0;
        endcase
    endtask

    function automatic int lat_of(input logic [4:0] o);
        if (o == OP_MULT || o == OP_MULTU) return MUL_LAT;
        if (o == OP_DIV || o == OP_DIVU) return DIV_LAT;
        return 1;
    endfunction

    // ---------------- driver ----------------
    task automatic run_op(input logic [4:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] er;
        logic ef;
        int lat, guard, exp_lat;
        bit rdy_seen;
        exp_lat = lat_of(o);
        model(o, a, b, er, ef);
        @(negedge clk);
        op = o; in_0 = a; in_1 = b; in_valid = 1'b1; out_ready = 1'b1;
        guard = 0;
        while (!in_ready && guard < 100) begin @(negedge clk); guard++; end
        chk("accept_timeout", (guard < 100) ? 1 : 0, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        rdy_seen = 1'b0;
        while (!out_valid && lat < 100) begin
            if (in_ready) rdy_seen = 1'b1;
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", lat, exp_lat);
        chk("out", out, er);
        chk("of", of, ef);
        chk("hi", hi, m_hi);
        chk("lo", lo, m_lo);
        if (exp_lat > 1) chk("busy_in_ready", rdy_seen, 0);
    endtask

    localparam logic [W-1:0] CORNERS [6] = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h7FFFFFFF,
                                             32'h80000000, 32'h2};
    localparam logic [4:0] OPS [22] = '{OP_ADD, OP_ADDU, OP_SUB, OP_SUBU, OP_AND, OP_OR,
                                        OP_XOR, OP_NOR, OP_SLT, OP_SLTU, OP_SLL, OP_SRL,
                                        OP_SRA, OP_SLA, OP_MULT, OP_MULTU, OP_DIV, OP_DIVU,
                                        OP_MFHI, OP_MFLO, OP_MTHI, OP_MTLO};

    function automatic logic [W-1:0] pick();
        if ($urandom_range(0, 3) == 0) return CORNERS[$urandom_range(0, 5)];
        return $urandom;
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        logic [W-1:0] held, er, save_hi, save_lo;
        logic ef;
        bit seen;

        // reset state
        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out", out, 0);
        chk("rst_of", of, 0);
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        @(negedge clk); rst_n = 1'b1;
        #1;
        chk("rst_in_ready", in_ready, 1);

        // overflow corners
        run_op(OP_ADD,  32'h7FFFFFFF, 32'h00000001);
        run_op(OP_ADDU, 32'h7FFFFFFF, 32'h00000001);
        run_op(OP_SUB,  32'h80000000, 32'h00000001);
        run_op(OP_SUBU, 32'h80000000, 32'h00000001);

        // multiply / divide corners, then HI/LO moves
        run_op(OP_MULT, 32'hFFFFFFFE, 32'h00000003);
        run_op(OP_MFHI, 32'h0, 32'h0);
        run_op(OP_DIV,  32'hFFFFFFF9, 32'h00000002);
        run_op(OP_MFLO, 32'h0, 32'h0);
        run_op(OP_DIVU, 32'h00000005, 32'h00000000);
        run_op(OP_DIV,  32'hFFFFFFF9, 32'h00000000);
        run_op(OP_DIV,  32'h80000000, 32'hFFFFFFFF);
        run_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        run_op(OP_MTHI, 32'h12345678, 32'h0);
        run_op(OP_MTLO, 32'h9ABCDEF0, 32'h0);
        run_op(OP_SRA,  32'h00000024, 32'h80000000);

        // backpressure after an SLT result
        run_op(OP_SLT, 32'hFFFFFFFF, 32'h00000001);
        held = out;
        @(negedge clk);
        out_ready = 1'b0;
        op = OP_ADD; in_0 = 32'd40; in_1 = 32'd2; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_out_stable", out, held);
            chk("bp_out_valid", out_valid, 1);
            chk("bp_in_ready", in_ready, 0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", in_ready, 1);
        model(OP_ADD, 32'd40, 32'd2, er, ef);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("bp_same_edge_valid", out_valid, 1);
        chk("bp_same_edge_out", out, er);

        // flush at cycle 10 of a DIV
        save_hi = m_hi;
        save_lo = m_lo;
        @(negedge clk);
        op = OP_DIV; in_0 = 32'd1000; in_1 = 32'd7; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk); flush = 1'b1;
        @(posedge clk); #1; flush = 1'b0;
        chk("flush_out_valid", out_valid, 0);
        chk("flush_of", of, 0);
        chk("flush_state_idle", dbg_state, 0);
        seen = 1'b0;
        repeat (40) begin @(posedge clk); #1; if (out_valid) seen = 1'b1; end
        chk("flush_no_result", seen, 0);
        chk("flush_hi_kept", hi, save_hi);
        chk("flush_lo_kept", lo, save_lo);

        // asynchronous reset in the middle of an iterative op
        @(negedge clk);
`ifdef ALU_FAST_MUL_EN
        op = OP_DIV;
`else
        op = OP_MULT;
`endif
        in_0 = 32'hDEADBEEF; in_1 = 32'h1234567; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_out", out, 0);
        chk("arst_of", of, 0);
        chk("arst_hi", hi, 0);
        chk("arst_lo", lo, 0);
        chk("arst_in_ready", in_ready, 1);
        @(negedge clk); rst_n = 1'b1;
        m_hi = '0;
        m_lo = '0;

        // randomized ops against the model
        for (int i = 0; i < 250; i++) begin
            run_op(OPS[$urandom_range(0, 21)], pick(), pick());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "timeout");
    end
endmodule
